// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator family:
// flag positions, FSM states and the flag-vector builder.
package comparator_pkg;

  localparam int F_EQ = 5;
  localparam int F_NE = 4;
  localparam int F_GT = 3;
  localparam int F_LT = 2;
  localparam int F_GE = 1;
  localparam int F_LE = 0;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic logic [5:0] mk_flags(
    input logic eq,
    input logic gt,
    input logic lt
  );
    logic [5:0] f;
    f       = '0;
    f[F_EQ] = eq;
    f[F_NE] = ~eq;
    f[F_GT] = gt;
    f[F_LT] = lt;
    f[F_GE] = gt | eq;
    f[F_LE] = lt | eq;
    return f;
  endfunction

endpackage

// File: rtl/comparator_digit.sv
// Combinational unsigned compare of one DIGIT-wide pair.
// Produces the gt/lt/eq relation of a versus b.
module comparator_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/serial_comparator.sv
// Digit-serial MSB-first magnitude comparator with
// signed/unsigned mode and optional early termination.
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [5:0]       y
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_e r_state;
  state_e w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_dec;
  logic             r_gt;
  logic             r_lt;
  logic [5:0]       r_y;
  logic             r_done;

  logic w_dgt;
  logic w_dlt;
  logic w_deq;
  logic w_gt;
  logic w_lt;
  logic w_dec;
  logic w_fin;
  logic [WIDTH-1:0] w_flip;

  comparator_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a  (r_a[WIDTH-1 -: DIGIT]),
    .b  (r_b[WIDTH-1 -: DIGIT]),
    .gt (w_dgt),
    .lt (w_dlt),
    .eq (w_deq)
  );

  // Biasing the sign bit maps two's-complement order onto unsigned order.
  assign w_flip = signed_mode ? MSB : '0;

  always_comb begin
    w_gt  = r_dec ? r_gt : w_dgt;
    w_lt  = r_dec ? r_lt : w_dlt;
    w_dec = r_dec | ~w_deq;
    w_fin = (r_state == RUN) &&
            ((r_cnt == LAST) || ((EARLY_EXIT != 0) && w_dec));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN:  if (w_fin) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_dec  <= 1'b0;
      r_gt   <= 1'b0;
      r_lt   <= 1'b0;
      r_y    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && start) begin
        r_a   <= a ^ w_flip;
        r_b   <= b ^ w_flip;
        r_cnt <= '0;
        r_dec <= 1'b0;
        r_gt  <= 1'b0;
        r_lt  <= 1'b0;
      end else if (r_state == RUN) begin
        r_a   <= r_a << DIGIT;
        r_b   <= r_b << DIGIT;
        r_cnt <= r_cnt + 1'b1;
        r_dec <= w_dec;
        r_gt  <= w_gt;
        r_lt  <= w_lt;
        if (w_fin) begin
          r_y    <= mk_flags(~(w_gt | w_lt), w_gt, w_lt);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign y    = r_y;

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: directed cases plus random
// operands on early-exit and fixed-latency instances.
module tb_serial_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sm  = 1'b0;
  logic [7:0] a   = '0;
  logic [7:0] b   = '0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       busy0, busy1;
  logic       done0, done1;
  logic [5:0] y0, y1;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_comparator #(
    .WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)
  ) dut_ee (
    .clk(clk), .rst(rst), .start(start0),
    .signed_mode(sm), .a(a), .b(b),
    .busy(busy0), .done(done0), .y(y0)
  );

  serial_comparator #(
    .WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)
  ) dut_fx (
    .clk(clk), .rst(rst), .start(start1),
    .signed_mode(sm), .a(a), .b(b),
    .busy(busy1), .done(done1), .y(y1)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ref_y(input logic [7:0] x,
                                       input logic [7:0] z,
                                       input logic s);
    int va, vb;
    logic eq, gt, lt;
    va = s ? int'($signed(x)) : int'(x);
    vb = s ? int'($signed(z)) : int'(z);
    eq = (va == vb);
    gt = (va > vb);
    lt = (va < vb);
    return {eq, !eq, gt, lt, gt | eq, lt | eq};
  endfunction

  function automatic int ref_k(input logic [7:0] x,
                               input logic [7:0] z,
                               input logic ee);
    logic [7:0] d;
    d = x ^ z;
    if (!ee || d == 0) return 4;
    for (int i = 0; i < 4; i++)
      if (((d >> (6 - 2 * i)) & 8'd3) != 0) return i + 1;
    return 4;
  endfunction

  function automatic logic get_done(input logic s);
    return s ? done1 : done0;
  endfunction

  function automatic logic get_busy(input logic s);
    return s ? busy1 : busy0;
  endfunction

  function automatic logic [5:0] get_y(input logic s);
    return s ? y1 : y0;
  endfunction

  // Drive a request and consume the sampling edge E0.
  task automatic launch(input logic s, input logic [7:0] x,
                        input logic [7:0] z, input logic m);
    a = x; b = z; sm = m;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    check("busy_after_start", 32'(get_busy(s)), 32'd1);
  endtask

  // Count edges after E0 until done; leaves time in the done cycle.
  task automatic finish(input logic s, input logic [7:0] x,
                        input logic [7:0] z, input logic m,
                        input string tag);
    int k;
    k = 0;
    while (!get_done(s) && k < 12) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(ref_k(x, z, !s)));
    check({tag, "_y"}, 32'(get_y(s)), 32'(ref_y(x, z, m)));
    check({tag, "_busy_done"}, 32'(get_busy(s)), 32'd0);
  endtask

  task automatic run(input logic s, input logic [7:0] x,
                     input logic [7:0] z, input logic m,
                     input string tag);
    @(negedge clk);
    launch(s, x, z, m);
    finish(s, x, z, m, tag);
  endtask

  initial begin
    int dcount;
    logic [7:0] ra, rb;
    logic rm;

    #12;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_y", 32'(y0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(1'b0, 8'h5A, 8'h5A, 1'b0, "eq5a");
    check("eq5a_const", 32'(y0), 32'h23);
    run(1'b0, 8'h80, 8'h7F, 1'b0, "u80");
    check("u80_const", 32'(y0), 32'h1A);
    run(1'b0, 8'h80, 8'h7F, 1'b1, "s80");
    check("s80_const", 32'(y0), 32'h15);
    run(1'b1, 8'h80, 8'h7F, 1'b0, "fx80");
    run(1'b1, 8'h03, 8'h02, 1'b0, "fx03");
    check("fx03_const", 32'(y1), 32'h1A);

    // A start during RUN must be ignored.
    @(negedge clk);
    launch(1'b0, 8'h10, 8'h20, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done0) dcount++;
    end
    check("ign_y", 32'(y0), 32'h15);
    check("ign_pulses", 32'(dcount), 32'd1);

    // Reset in the middle of a compare.
    @(negedge clk);
    launch(1'b0, 8'h00, 8'h01, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_done", 32'(done0), 32'd0);
    check("mid_rst_y", 32'(y0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done0) dcount++;
    end
    check("mid_rst_nodone", 32'(dcount), 32'd0);
    run(1'b0, 8'hC3, 8'hC1, 1'b1, "post_rst");

    // Start in the done cycle is accepted.
    run(1'b0, 8'h40, 8'h41, 1'b0, "b2b_first");
    launch(1'b0, 8'hF0, 8'h0F, 1'b1);
    finish(1'b0, 8'hF0, 8'h0F, 1'b1, "b2b_second");
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done0), 32'd0);

    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      rm = 1'($urandom);
      run(1'(i & 1), ra, rb, rm, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
# serial_comparator

Parametrised, digit-serial magnitude comparator: compares two WIDTH-bit operands DIGIT bits per cycle, MSB-first, in unsigned or two's-complement mode, with optional early termination. It is the sequential successor to the team's combinational 1-/2-bit comparators. It emits the same six-flag result vector, so downstream flag consumers are unchanged. It serves area-constrained datapaths where a full-width parallel compare is not wanted.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits examined per cycle; 1 ≤ DIGIT ≤ WIDTH.
- EARLY_EXIT, 1, 1 = finish on the first differing digit; 0 = always run all digits (fixed latency).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's complement, 0 = unsigned; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when y becomes valid.
- y  output  6  result flags: [5] eq, [4] ne, [3] gt (A>B), [2] lt (A<B), [1] ge, [0] le.

## Operation
- NDIG = WIDTH/DIGIT. Digit i (i=0 is most significant) = bits [WIDTH-1-i*DIGIT -: DIGIT].
- States: IDLE, RUN. Reset → IDLE, busy=0, done=0, y=6'b000000.
- IDLE, start=1: latch a, b, signed_mode; clear decided flag, gt/lt registers and digit counter; go to RUN.
- Signed mode: invert bit WIDTH-1 of both latched operands. An unsigned compare then yields the signed order.
- RUN, per cycle: compare the current digit pair.
  - If the pair is unequal and nothing is decided yet, record gt or lt and set the decided flag. Later digits never override a decided result.
  - Leave RUN after the last digit (counter = NDIG-1), or, with EARLY_EXIT=1, on the cycle that decides.
- On leaving RUN: y ← {eq, ~eq, gt, lt, gt|eq, lt|eq}, done=1 for one cycle, return to IDLE.
- y holds its value until the next completion or reset.
- start while busy: ignored; operands are not re-latched.
- start in the done cycle: accepted, because the FSM is already in IDLE.
- Operand/mode inputs change during RUN: no effect on the result.
- Reset mid-RUN: immediately IDLE, busy=0, done=0, y cleared. No done is produced for the aborted compare.

## Timing
- Start sampled at edge E0. RUN occupies edges E1..Ek. done=1 and y valid in the cycle after edge Ek. busy=1 from after E0 through Ek.
- k = NDIG when EARLY_EXIT=0, or when the operands are equal.
- Otherwise k = 1 + index of the first differing digit.
- Minimum latency 1 cycle (start edge → done cycle). Maximum latency NDIG cycles.
- Throughput: one compare per k+1 cycles with back-to-back start.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package, comparator_pkg, holds:
  - flag index constants (F_EQ=5, F_NE=4, F_GT=3, F_LT=2, F_GE=1, F_LE=0);
  - the state enum {IDLE, RUN};
  - a function that builds the 6-bit flag vector from eq/gt/lt.
- One sub-module, comparator_digit: combinational, parametrised by DIGIT, outputs gt/lt/eq for one digit pair.
- Top level holds the FSM, digit counter (clog2(NDIG) bits, minimum 1), operand shift registers and result registers.

## Test plan
- WIDTH=8, DIGIT=2, EARLY_EXIT=1, unsigned, a=0x5A, b=0x5A → done 4 cycles after start, y=6'b100011, busy low in the done cycle.
- Same configuration, unsigned, a=0x80, b=0x7F → done 1 cycle after start, y=6'b011010. Repeat with signed_mode=1 → y=6'b010101.
- EARLY_EXIT=0, a=0x80, b=0x7F, unsigned → done exactly 4 cycles after start, y=6'b011010. Also a=0x03, b=0x02 → done after 4 cycles, y=6'b011010.
- Start a=0x10, b=0x20; pulse start with a=0xFF, b=0x00 during RUN → second request ignored, y=6'b010101 (lt), exactly one done pulse.
- Assert rst mid-RUN → busy=0, done=0, y=0 asynchronously; no done afterward. A new start then completes normally.
- Assert start in the done cycle with new operands → accepted, busy high next cycle, second result correct. Sweep all 8-bit pairs in both modes against a reference model.
